// File: rtl/battle_turn_engine_if.sv
// battle_turn_engine_if: bundles the battle engine's lookup, keyboard, CPU handshake and overlay signals.
// Optional BATTLE_CRIT_EN adds the crit output.
interface battle_turn_engine_if #(
    parameter int TEAM_SIZE = 3,
    parameter int HP_W      = 8,
    parameter int NUM_MOVES = 4
);
    localparam int IW = (TEAM_SIZE > 1) ? $clog2(TEAM_SIZE) : 1;
    localparam int MW = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;

    logic            is_battle;
    logic [7:0]      keycode;
    logic [HP_W-1:0] player_max_hp;
    logic [HP_W-1:0] enemy_max_hp;
    logic [7:0]      player_speed;
    logic [7:0]      enemy_speed;
    logic [HP_W-1:0] player_dmg;
    logic [HP_W-1:0] enemy_dmg;
    logic [7:0]      player_acc;
    logic [7:0]      enemy_acc;
    logic [7:0]      rnd;
    logic            cpu_done;
    logic [MW-1:0]   cpu_move;
    logic            cpu_req;
    logic [IW-1:0]   cur_mon;
    logic [IW-1:0]   opp_mon;
    logic [HP_W-1:0] player_hp;
    logic [HP_W-1:0] enemy_hp;
    logic [MW-1:0]   move_index;
    logic [MW-1:0]   enemy_move;
    logic            attacker;
    logic            hit;
    logic            busy;
    logic [3:0]      state_code;
    logic            end_battle;
    logic            result;
`ifdef BATTLE_CRIT_EN
    logic            crit;
`endif

    modport master (
`ifdef BATTLE_CRIT_EN
        input  crit,
`endif
        output is_battle, keycode, player_max_hp, enemy_max_hp, player_speed, enemy_speed,
        output player_dmg, enemy_dmg, player_acc, enemy_acc, rnd, cpu_done, cpu_move,
        input  cpu_req, cur_mon, opp_mon, player_hp, enemy_hp, move_index, enemy_move,
        input  attacker, hit, busy, state_code, end_battle, result
    );

    modport slave (
`ifdef BATTLE_CRIT_EN
        output crit,
`endif
        input  is_battle, keycode, player_max_hp, enemy_max_hp, player_speed, enemy_speed,
        input  player_dmg, enemy_dmg, player_acc, enemy_acc, rnd, cpu_done, cpu_move,
        output cpu_req, cur_mon, opp_mon, player_hp, enemy_hp, move_index, enemy_move,
        output attacker, hit, busy, state_code, end_battle, result
    );
endinterface

// File: rtl/battle_turn_engine.sv
// battle_turn_engine: speed-ordered battle turn sequencer with edge-detected keys, animated HP drain and faint auto-switch.
// Optional BATTLE_CRIT_EN doubles damage on a critical hit and drives the crit output.
module battle_turn_engine #(
    parameter int TEAM_SIZE = 3,
    parameter int HP_W      = 8,
    parameter int NUM_MOVES = 4,
    parameter int DRAIN_DIV = 1024
) (
    input logic                  Clk,
    input logic                  Reset,
    battle_turn_engine_if.slave  bus
);
    localparam int IW = (TEAM_SIZE > 1) ? $clog2(TEAM_SIZE) : 1;
    localparam int MW = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;
    localparam int CW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07, K_ENTER = 8'h28;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_LOAD, S_SELECT, S_CPU_WAIT, S_ATTACK,
        S_DRAIN, S_TEXT, S_SWITCH, S_WIN, S_LOSE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      key_prev_q;
    logic [IW-1:0]   cur_mon_q, cur_mon_d, opp_mon_q, opp_mon_d;
    logic [HP_W-1:0] player_hp_q, player_hp_d, enemy_hp_q, enemy_hp_d, target_q, target_d;
    logic [MW-1:0]   move_index_q, move_index_d, enemy_move_q, enemy_move_d;
    logic            attacker_q, attacker_d, hit_q, hit_d, pending_q, pending_d;
    logic            result_q, result_d, ld_p_q, ld_p_d, ld_e_q, ld_e_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            key_press, enter, def_last, hit_now;
    logic [HP_W-1:0] def_hp, atk_dmg, eff_dmg, tgt_now;
    logic [7:0]      atk_acc, roll;
`ifdef BATTLE_CRIT_EN
    logic            crit_q, crit_d, crit_now;
    logic [HP_W:0]   dbl_dmg;
`endif

    assign key_press = (bus.keycode != 8'h00) && (bus.keycode != key_prev_q);
    assign enter     = key_press && (bus.keycode == K_ENTER);
    assign def_hp    = attacker_q ? enemy_hp_q : player_hp_q;
    assign def_last  = (attacker_q ? opp_mon_q : cur_mon_q) == IW'(TEAM_SIZE - 1);
    assign atk_acc   = attacker_q ? bus.player_acc : bus.enemy_acc;
    assign atk_dmg   = attacker_q ? bus.player_dmg : bus.enemy_dmg;
    assign roll      = bus.rnd % 8'd100;
    assign hit_now   = ({1'b0, roll} + 9'd1) <= {1'b0, atk_acc};
`ifdef BATTLE_CRIT_EN
    assign crit_now  = hit_now && (bus.rnd[7:4] == 4'h0);
    assign dbl_dmg   = {1'b0, atk_dmg} << 1;
    assign eff_dmg   = !crit_now ? atk_dmg : dbl_dmg[HP_W] ? '1 : dbl_dmg[HP_W-1:0];
`else
    assign eff_dmg   = atk_dmg;
`endif
    // HP after this attack: unchanged on a miss, otherwise reduced and clamped at zero
    assign tgt_now   = !hit_now ? def_hp : (def_hp > eff_dmg) ? def_hp - eff_dmg : '0;

    // State and datapath registers; reset clears every visible output
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            key_prev_q   <= 8'h00;
            cur_mon_q    <= '0;
            opp_mon_q    <= '0;
            player_hp_q  <= '0;
            enemy_hp_q   <= '0;
            target_q     <= '0;
            move_index_q <= '0;
            enemy_move_q <= '0;
            attacker_q   <= 1'b0;
            hit_q        <= 1'b0;
            pending_q    <= 1'b0;
            result_q     <= 1'b0;
            ld_p_q       <= 1'b0;
            ld_e_q       <= 1'b0;
            cnt_q        <= '0;
`ifdef BATTLE_CRIT_EN
            crit_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            key_prev_q   <= bus.keycode;
            cur_mon_q    <= cur_mon_d;
            opp_mon_q    <= opp_mon_d;
            player_hp_q  <= player_hp_d;
            enemy_hp_q   <= enemy_hp_d;
            target_q     <= target_d;
            move_index_q <= move_index_d;
            enemy_move_q <= enemy_move_d;
            attacker_q   <= attacker_d;
            hit_q        <= hit_d;
            pending_q    <= pending_d;
            result_q     <= result_d;
            ld_p_q       <= ld_p_d;
            ld_e_q       <= ld_e_d;
            cnt_q        <= cnt_d;
`ifdef BATTLE_CRIT_EN
            crit_q       <= crit_d;
`endif
        end
    end

    // Next-state logic of the turn sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = bus.is_battle ? S_START : S_IDLE;
            S_START:    state_d = S_LOAD;
            S_LOAD:     state_d = S_SELECT;
            S_SELECT:   state_d = enter ? S_CPU_WAIT : S_SELECT;
            S_CPU_WAIT: state_d = bus.cpu_done ? S_ATTACK : S_CPU_WAIT;
            S_ATTACK:   state_d = (hit_now && eff_dmg != '0) ? S_DRAIN : S_TEXT;
            S_DRAIN:    state_d = (def_hp == target_q) ? S_TEXT : S_DRAIN;
            S_TEXT:     state_d = !enter ? S_TEXT :
                                  (def_hp == '0) ? (def_last ? (attacker_q ? S_WIN : S_LOSE) : S_SWITCH) :
                                  pending_q ? S_ATTACK : S_SELECT;
            S_SWITCH:   state_d = S_LOAD;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath updates: HP loads, cursor moves, attack resolution, drain stepping and slot switching
    always_comb begin
        cur_mon_d    = cur_mon_q;
        opp_mon_d    = opp_mon_q;
        player_hp_d  = player_hp_q;
        enemy_hp_d   = enemy_hp_q;
        target_d     = target_q;
        move_index_d = move_index_q;
        enemy_move_d = enemy_move_q;
        attacker_d   = attacker_q;
        hit_d        = hit_q;
        pending_d    = pending_q;
        result_d     = result_q;
        ld_p_d       = ld_p_q;
        ld_e_d       = ld_e_q;
        cnt_d        = cnt_q;
`ifdef BATTLE_CRIT_EN
        crit_d       = crit_q;
`endif
        case (state_q)
            S_START: begin
                cur_mon_d    = '0;
                opp_mon_d    = '0;
                result_d     = 1'b0;
                move_index_d = '0;
                pending_d    = 1'b0;
                ld_p_d       = 1'b1;
                ld_e_d       = 1'b1;
            end
            S_LOAD: begin
                player_hp_d = ld_p_q ? bus.player_max_hp : player_hp_q;
                enemy_hp_d  = ld_e_q ? bus.enemy_max_hp : enemy_hp_q;
                ld_p_d      = 1'b0;
                ld_e_d      = 1'b0;
            end
            S_SELECT: begin
                if (key_press) begin
                    case (bus.keycode)
                        K_W:     move_index_d = (32'(move_index_q) >= 2) ? move_index_q - MW'(2) : move_index_q;
                        K_S:     move_index_d = (32'(move_index_q) + 2 < NUM_MOVES) ? move_index_q + MW'(2) : move_index_q;
                        K_A:     move_index_d = move_index_q[0] ? move_index_q - MW'(1) : move_index_q;
                        K_D:     move_index_d = move_index_q[0] ? move_index_q : move_index_q + MW'(1);
                        default: move_index_d = move_index_q;
                    endcase
                end
            end
            S_CPU_WAIT: begin
                if (bus.cpu_done) begin
                    enemy_move_d = bus.cpu_move;
                    attacker_d   = bus.player_speed > bus.enemy_speed;
                    pending_d    = 1'b1;
                end
            end
            S_ATTACK: begin
                hit_d    = hit_now;
                target_d = tgt_now;
                cnt_d    = '0;
`ifdef BATTLE_CRIT_EN
                crit_d   = crit_now;
`endif
            end
            S_DRAIN: begin
                if (def_hp != target_q) begin
                    cnt_d = (cnt_q == CW'(DRAIN_DIV - 1)) ? '0 : cnt_q + CW'(1);
                    if (cnt_q == CW'(DRAIN_DIV - 1)) begin
                        if (attacker_q) enemy_hp_d = enemy_hp_q - HP_W'(1);
                        else player_hp_d = player_hp_q - HP_W'(1);
                    end
                end
            end
            S_TEXT: begin
                if (enter && def_hp != '0 && pending_q) begin
                    pending_d  = 1'b0;
                    attacker_d = !attacker_q;
                end
            end
            S_SWITCH: begin
                pending_d = 1'b0;
                if (attacker_q) begin
                    opp_mon_d = opp_mon_q + IW'(1);
                    ld_e_d    = 1'b1;
                end else begin
                    cur_mon_d = cur_mon_q + IW'(1);
                    ld_p_d    = 1'b1;
                end
            end
            S_WIN:   result_d = 1'b1;
            default: result_d = result_q;
        endcase
    end

    // Overlay and handshake outputs decoded from state and registers
    always_comb begin
        bus.cpu_req    = state_q == S_CPU_WAIT;
        bus.busy       = state_q == S_DRAIN;
        bus.end_battle = (state_q == S_WIN) || (state_q == S_LOSE);
        bus.state_code = state_q;
        bus.cur_mon    = cur_mon_q;
        bus.opp_mon    = opp_mon_q;
        bus.player_hp  = player_hp_q;
        bus.enemy_hp   = enemy_hp_q;
        bus.move_index = move_index_q;
        bus.enemy_move = enemy_move_q;
        bus.attacker   = attacker_q;
        bus.hit        = hit_q;
        bus.result     = result_q;
`ifdef BATTLE_CRIT_EN
        bus.crit       = crit_q && (state_q == S_DRAIN || state_q == S_TEXT);
`endif
    end
endmodule

// File: tb/tb_battle_turn_engine.sv
// tb_battle_turn_engine: directed and randomized battles checked against a turn-level model of the battle rules.
module tb_battle_turn_engine;
    localparam int TS = 3, HW = 8, NM = 4, DD = 4;
    localparam logic [3:0] C_IDLE = 4'd0, C_START = 4'd1, C_LOAD = 4'd2, C_SELECT = 4'd3, C_CPU = 4'd4,
                           C_ATTACK = 4'd5, C_DRAIN = 4'd6, C_TEXT = 4'd7, C_WIN = 4'd9, C_LOSE = 4'd10;
    localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07, K_EN = 8'h28;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int checks = 0, failures = 0;
    int p_max[TS] = '{30, 40, 50};
    int e_max[TS] = '{5, 40, 60};
    logic [7:0] keys[4] = '{K_W, K_A, K_S, K_D};
    logic [7:0] nav_k[13] = '{K_D, K_S, K_A, K_W, K_A, K_W, K_S, K_S, K_D, K_D, K_A, K_W, K_A};
    int nav_e[13] = '{1, 3, 2, 0, 0, 0, 2, 2, 3, 3, 2, 0, 0};
    int php, ehp, pm, em, idx, pd, ed, pa, ea, ps, es;
    logic [7:0] rv;
    bit bias;

    battle_turn_engine_if #(.TEAM_SIZE(TS), .HP_W(HW), .NUM_MOVES(NM)) bus ();
    battle_turn_engine #(.TEAM_SIZE(TS), .HP_W(HW), .NUM_MOVES(NM), .DRAIN_DIV(DD)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.slave));

    always #5 Clk = ~Clk;
    assign bus.player_max_hp = HW'(p_max[bus.cur_mon]);
    assign bus.enemy_max_hp  = HW'(e_max[bus.opp_mon]);

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        bus.keycode = k;
        tick();
        bus.keycode = 8'h00;
        tick();
    endtask

    task automatic wait_text();
        int n = 0;
        while (bus.state_code != C_TEXT && n < 400 * DD) begin
            tick();
            n++;
        end
        chk("reach_text", 32'(bus.state_code), 32'(C_TEXT));
    endtask

    task automatic set_atk();
        pd = bias ? $urandom_range(20, 60) : $urandom_range(0, 5);
        ed = bias ? $urandom_range(0, 5) : $urandom_range(20, 60);
        pa = $urandom_range(1, 100);
        ea = $urandom_range(1, 100);
        rv = 8'($urandom_range(0, 255));
        bus.player_dmg = HW'(pd);
        bus.enemy_dmg  = HW'(ed);
        bus.player_acc = 8'(pa);
        bus.enemy_acc  = 8'(ea);
        bus.rnd        = rv;
    endtask

    // Called with the DUT in ATTACK; resolves the attack and follows it to TEXT
    task automatic run_attack(input bit patk);
        int acc, dmg, def, nhp;
        bit h;
        acc = patk ? pa : ea;
        dmg = patk ? pd : ed;
        h = ((int'(rv) % 100) + 1) <= acc;
`ifdef BATTLE_CRIT_EN
        if (h && rv[7:4] == 4'h0) dmg = (dmg * 2 > (1 << HW) - 1) ? (1 << HW) - 1 : dmg * 2;
`endif
        def = patk ? ehp : php;
        nhp = !h ? def : (def > dmg ? def - dmg : 0);
        chk("attack_state", 32'(bus.state_code), 32'(C_ATTACK));
        chk("attacker", 32'(bus.attacker), 32'(patk));
        tick();
        wait_text();
        chk("hit", 32'(bus.hit), 32'(h));
        if (patk) begin
            ehp = nhp;
            chk("enemy_hp_after", 32'(bus.enemy_hp), 32'(ehp));
        end else begin
            php = nhp;
            chk("player_hp_after", 32'(bus.player_hp), 32'(php));
        end
    endtask

    task automatic play_turn(output bit done);
        bit patk, pending, fin;
        int row, col, k, mv, dh, ds;
        done = 0;
        repeat ($urandom_range(0, 3)) begin
            k = $urandom_range(0, 3);
            row = idx / 2;
            col = idx % 2;
            if (k == 0 && row > 0) row--;
            if (k == 2 && row < NM / 2 - 1) row++;
            if (k == 1) col = 0;
            if (k == 3) col = 1;
            idx = row * 2 + col;
            press(keys[k]);
            chk("nav_idx", 32'(bus.move_index), 32'(idx));
        end
        ps = $urandom_range(1, 100);
        es = $urandom_range(1, 100);
        bus.player_speed = 8'(ps);
        bus.enemy_speed  = 8'(es);
        set_atk();
        press(K_EN);
        chk("cpu_wait", 32'(bus.state_code), 32'(C_CPU));
        repeat ($urandom_range(0, 3)) tick();
        chk("cpu_req", 32'(bus.cpu_req), 32'd1);
        mv = $urandom_range(0, NM - 1);
        bus.cpu_move = 2'(mv);
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        chk("enemy_move", 32'(bus.enemy_move), 32'(mv));
        patk = ps > es;
        pending = 1;
        fin = 0;
        while (!fin) begin
            run_attack(patk);
            set_atk();
            dh = patk ? ehp : php;
            ds = patk ? em : pm;
            if (dh == 0 && ds == TS - 1) begin
                bus.keycode = K_EN;
                tick();
                chk("end_pulse", 32'(bus.end_battle), 32'd1);
                chk("end_state", 32'(bus.state_code), 32'(patk ? C_WIN : C_LOSE));
                bus.keycode = 8'h00;
                tick();
                chk("end_pulse_off", 32'(bus.end_battle), 32'd0);
                chk("idle_after_end", 32'(bus.state_code), 32'(C_IDLE));
                chk("result", 32'(bus.result), 32'(patk));
                done = 1;
                fin = 1;
            end else if (dh == 0) begin
                press(K_EN);
                chk("switch_load", 32'(bus.state_code), 32'(C_LOAD));
                if (patk) begin
                    em++;
                    ehp = e_max[em];
                    chk("opp_mon", 32'(bus.opp_mon), 32'(em));
                end else begin
                    pm++;
                    php = p_max[pm];
                    chk("cur_mon", 32'(bus.cur_mon), 32'(pm));
                end
                tick();
                chk("switch_select", 32'(bus.state_code), 32'(C_SELECT));
                chk("switch_php", 32'(bus.player_hp), 32'(php));
                chk("switch_ehp", 32'(bus.enemy_hp), 32'(ehp));
                fin = 1;
            end else if (pending) begin
                pending = 0;
                patk = !patk;
                bus.keycode = K_EN;
                tick();
                bus.keycode = 8'h00;
            end else begin
                press(K_EN);
                chk("turn_end", 32'(bus.state_code), 32'(C_SELECT));
                fin = 1;
            end
        end
    endtask

    task automatic start_battle();
        bus.is_battle = 1'b1;
        tick();
        chk("start", 32'(bus.state_code), 32'(C_START));
        bus.is_battle = 1'b0;
        tick();
        tick();
        chk("select_after_load", 32'(bus.state_code), 32'(C_SELECT));
        php = p_max[0];
        ehp = e_max[0];
        pm = 0;
        em = 0;
        idx = 0;
        chk("load_php", 32'(bus.player_hp), 32'(php));
        chk("load_ehp", 32'(bus.enemy_hp), 32'(ehp));
        chk("start_idx", 32'(bus.move_index), 32'd0);
        chk("start_result", 32'(bus.result), 32'd0);
    endtask

    task automatic finish_battle();
        bit done = 0;
        for (int t = 0; t < 80 && !done; t++) play_turn(done);
        chk("battle_done", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        bus.is_battle = 0; bus.keycode = 0; bus.player_speed = 0; bus.enemy_speed = 0;
        bus.player_dmg = 0; bus.enemy_dmg = 0; bus.player_acc = 0; bus.enemy_acc = 0;
        bus.rnd = 0; bus.cpu_done = 0; bus.cpu_move = 0;
        tick();
        tick();
        chk("rst_state", 32'(bus.state_code), 32'(C_IDLE));
        chk("rst_php", 32'(bus.player_hp), 32'd0);
        chk("rst_ehp", 32'(bus.enemy_hp), 32'd0);
        chk("rst_cur", 32'(bus.cur_mon), 32'd0);
        chk("rst_end", 32'(bus.end_battle), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        Reset = 1'b0;
        tick();
        chk("idle_hold", 32'(bus.state_code), 32'(C_IDLE));
        start_battle();
        for (int i = 0; i < 4; i++) begin
            press(nav_k[i]);
            chk("nav_a", 32'(bus.move_index), 32'(nav_e[i]));
        end
        bus.keycode = K_D;
        repeat (10) tick();
        bus.keycode = 8'h00;
        tick();
        chk("nav_hold", 32'(bus.move_index), 32'd1);
        for (int i = 4; i < 13; i++) begin
            press(nav_k[i]);
            chk("nav_b", 32'(bus.move_index), 32'(nav_e[i]));
        end
        bus.player_speed = 8'd50; bus.enemy_speed = 8'd50;
        bus.enemy_acc = 8'd100; bus.enemy_dmg = 8'd10;
        bus.player_acc = 8'd1; bus.player_dmg = 8'd20; bus.rnd = 8'd99;
        press(K_EN);
        chk("cpu_wait_d", 32'(bus.state_code), 32'(C_CPU));
        chk("cpu_req_d", 32'(bus.cpu_req), 32'd1);
        bus.cpu_move = 2'd2;
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        chk("tie_enemy_first", 32'(bus.attacker), 32'd0);
        chk("enemy_move_d", 32'(bus.enemy_move), 32'd2);
        tick();
        chk("drain_state", 32'(bus.state_code), 32'(C_DRAIN));
        chk("busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.state_code == C_DRAIN && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_len", 32'(n >= 10 * DD && n <= 10 * DD + 2), 32'd1);
        chk("drained_php", 32'(bus.player_hp), 32'd20);
        chk("busy_off", 32'(bus.busy), 32'd0);
        bus.keycode = K_EN;
        tick();
        bus.keycode = 8'h00;
        chk("second_attacker", 32'(bus.attacker), 32'd1);
        tick();
        chk("miss_text", 32'(bus.state_code), 32'(C_TEXT));
        chk("miss_hit", 32'(bus.hit), 32'd0);
        chk("miss_ehp", 32'(bus.enemy_hp), 32'd5);
        press(K_EN);
        chk("back_select", 32'(bus.state_code), 32'(C_SELECT));
        bus.player_speed = 8'd60;
        bus.player_acc = 8'd100;
        bus.enemy_dmg = 8'd7;
        press(K_EN);
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        chk("fast_player_first", 32'(bus.attacker), 32'd1);
        tick();
        wait_text();
        chk("no_wrap_ehp", 32'(bus.enemy_hp), 32'd0);
        press(K_EN);
        chk("switch_to_load", 32'(bus.state_code), 32'(C_LOAD));
        chk("opp_mon_1", 32'(bus.opp_mon), 32'd1);
        tick();
        chk("reload_ehp", 32'(bus.enemy_hp), 32'(e_max[1]));
        chk("keep_php", 32'(bus.player_hp), 32'd20);
        php = 20; ehp = e_max[1]; pm = 0; em = 1; idx = 0;
        bias = 1;
        finish_battle();
        for (int b = 0; b < 3; b++) begin
            bias = b[0] ? 1'b1 : 1'b0;
            start_battle();
            finish_battle();
        end
        bias = 0;
        start_battle();
        bus.player_speed = 8'd10; bus.enemy_speed = 8'd90;
        bus.enemy_acc = 8'd100; bus.enemy_dmg = 8'd15; bus.rnd = 8'd99;
        press(K_EN);
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        tick();
        chk("rst_drain_state", 32'(bus.state_code), 32'(C_DRAIN));
        repeat (3 * DD) tick();
        chk("mid_drain_php", 32'(bus.player_hp > 8'd15 && bus.player_hp < 8'd30), 32'd1);
        #3 Reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.state_code), 32'(C_IDLE));
        chk("async_rst_php", 32'(bus.player_hp), 32'd0);
        chk("async_rst_ehp", 32'(bus.enemy_hp), 32'd0);
        chk("async_rst_cur", 32'(bus.cur_mon), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(bus.state_code), 32'(C_IDLE));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
